// File: rtl/aes_pkg.sv
// AES state helpers shared by the round datapath, key schedule and reference models.
// Byte b = 4c + r of a 128-bit state sits at bits [127-8b -: 8] (column-major).
package aes_pkg;

  localparam int NB      = 4;
  localparam int STATE_W = 128;

  function automatic int idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  function automatic logic [STATE_W-1:0] shift_rows_fwd(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        o[STATE_W-1-8*idx(r, c) -: 8] = s[STATE_W-1-8*idx(r, (c + r) % NB) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [STATE_W-1:0] shift_rows_inv(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        // +NB keeps the modulo operand non-negative
        o[STATE_W-1-8*idx(r, c) -: 8] = s[STATE_W-1-8*idx(r, (c + NB - r) % NB) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows of one 128-bit state; pure wiring plus a 2:1 mux.
module shiftrows_perm
  import aes_pkg::*;
(
  input  logic               i_inv,
  input  logic [STATE_W-1:0] i_state,
  output logic [STATE_W-1:0] o_state
);

  logic [STATE_W-1:0] w_fwd;
  logic [STATE_W-1:0] w_inv;

  assign w_fwd   = shift_rows_fwd(i_state);
  assign w_inv   = shift_rows_inv(i_state);
  assign o_state = i_inv ? w_inv : w_fwd;

endmodule

// File: rtl/shiftrows_pipe.sv
// Flow-controlled ShiftRows stage: LANES states permuted on entry, held in a DEPTH-entry queue.
// One registered hop in->out; in_ready depends only on the stored count, never on out_ready.
module shiftrows_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_inv,
  input  logic [STATE_W*LANES-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_inv,
  output logic [STATE_W*LANES-1:0]   out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [STATE_W*LANES-1:0] w_xf;
  logic                     w_push;
  logic                     w_pop;

  logic [STATE_W*LANES-1:0] r_data [DEPTH];
  logic                     r_inv  [DEPTH];
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [CW-1:0]            r_count;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    shiftrows_perm u_perm (
      .i_inv   (in_inv),
      .i_state (in_data[STATE_W*k +: STATE_W]),
      .o_state (w_xf[STATE_W*k +: STATE_W])
    );
  end

  assign in_ready  = (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  // Stale entries stay in the array after a pop, so the head is masked when empty.
  assign out_data  = out_valid ? r_data[r_head] : '0;
  assign out_inv   = out_valid ? r_inv[r_head]  : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: nothing reads it until count says it is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= w_xf;
      r_inv[r_tail]  <= in_inv;
    end
  end

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Self-checking bench for shiftrows_pipe: a LANES=1 and a LANES=4 instance, both DEPTH=2.
module tb_shiftrows_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  // LANES=1 instance
  logic         v1, inv1, ordy1;
  logic [127:0] d1;
  logic         rdy1, ov1, oinv1;
  logic [127:0] od1;
  logic [1:0]   cnt1;

  shiftrows_pipe #(.LANES(1), .DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(rdy1), .in_inv(inv1), .in_data(d1),
    .out_valid(ov1), .out_ready(ordy1), .out_inv(oinv1), .out_data(od1),
    .count(cnt1)
  );

  // LANES=4 instance
  logic         v4, inv4, ordy4;
  logic [511:0] d4;
  logic         rdy4, ov4, oinv4;
  logic [511:0] od4;
  logic [1:0]   cnt4;

  shiftrows_pipe #(.LANES(4), .DEPTH(2)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4), .in_ready(rdy4), .in_inv(inv4), .in_data(d4),
    .out_valid(ov4), .out_ready(ordy4), .out_inv(oinv4), .out_data(od4),
    .count(cnt4)
  );

  // Reference: view the state as a 4x4 byte matrix and rotate each row r by r columns.
  function automatic logic [127:0] ref_sr(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4][4];
    logic [127:0] o;
    int           src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = s[127 - 8*(4*c + r) -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127 - 8*(4*c + r) -: 8] = m[r][src];
      end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", rdy1); end
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov1); end
    n_checks++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt1); end
    n_checks++; if (od1 !== 128'd0 || oinv1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_data: got %h/%b want 0/0", od1, oinv1); end
    n_checks++; if (od4 !== 512'd0 || rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_lanes4: got %h rdy %b want 0 rdy 1", od4, rdy4); end
    rst = 1'b0;
    tick();
  endtask

  // Push one vector into an empty dut1, check the head, then drain it.
  task automatic push_and_check(input string name, input logic [127:0] din, input logic inv,
                                input logic [127:0] want);
    v1 = 1'b1; d1 = din; inv1 = inv;
    tick();
    v1 = 1'b0;
    n_checks++; if (ov1 !== 1'b1 || cnt1 !== 2'd1) begin n_fail++; $display("FAIL %s_valid: got ov %b cnt %0d want 1/1", name, ov1, cnt1); end
    n_checks++; if (od1 !== want) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, od1, want); end
    n_checks++; if (oinv1 !== inv) begin n_fail++; $display("FAIL %s_inv: got %b want %b", name, oinv1, inv); end
    ordy1 = 1'b1;
    tick();
    ordy1 = 1'b0;
    n_checks++; if (cnt1 !== 2'd0 || ov1 !== 1'b0 || od1 !== 128'd0) begin n_fail++; $display("FAIL %s_drain: got cnt %0d ov %b data %h want 0/0/0", name, cnt1, ov1, od1); end
  endtask

  task automatic test_fips_forward();
    push_and_check("fips_fwd", FIPS_IN, 1'b0, FIPS_OUT);
  endtask

  task automatic test_inverse_round_trip();
    push_and_check("fips_inv", FIPS_OUT, 1'b1, FIPS_IN);
  endtask

  task automatic test_random_single();
    logic [127:0] x;
    logic         m;
    for (int i = 0; i < 4; i++) begin
      x = rnd128();
      m = 1'($urandom_range(0, 1));
      push_and_check("rand_single", x, m, ref_sr(x, m));
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] a, b, c;
    logic         ia, ib, ic;
    a = rnd128(); b = rnd128(); c = rnd128();
    ia = 1'($urandom_range(0, 1)); ib = ~ia; ic = 1'($urandom_range(0, 1));
    ordy1 = 1'b0;
    v1 = 1'b1; d1 = a; inv1 = ia;
    tick();
    n_checks++; if (cnt1 !== 2'd1 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL bp_first: got cnt %0d rdy %b want 1/1", cnt1, rdy1); end
    d1 = b; inv1 = ib;
    tick();
    n_checks++; if (cnt1 !== 2'd2 || rdy1 !== 1'b0) begin n_fail++; $display("FAIL bp_full: got cnt %0d rdy %b want 2/0", cnt1, rdy1); end
    d1 = c; inv1 = ic;
    repeat (3) tick();
    n_checks++; if (cnt1 !== 2'd2 || rdy1 !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got cnt %0d rdy %b want 2/0", cnt1, rdy1); end
    n_checks++; if (od1 !== ref_sr(a, ia) || oinv1 !== ia) begin n_fail++; $display("FAIL bp_head_a: got %h/%b want %h/%b", od1, oinv1, ref_sr(a, ia), ia); end
    // Pop while full: the offered third transfer must not slip in on the same edge.
    ordy1 = 1'b1;
    tick();
    ordy1 = 1'b0;
    n_checks++; if (cnt1 !== 2'd1 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL bp_pop_full: got cnt %0d rdy %b want 1/1", cnt1, rdy1); end
    n_checks++; if (od1 !== ref_sr(b, ib) || oinv1 !== ib) begin n_fail++; $display("FAIL bp_head_b: got %h/%b want %h/%b", od1, oinv1, ref_sr(b, ib), ib); end
    tick();
    v1 = 1'b0;
    n_checks++; if (cnt1 !== 2'd2) begin n_fail++; $display("FAIL bp_third_push: got cnt %0d want 2", cnt1); end
    ordy1 = 1'b1;
    tick();
    n_checks++; if (od1 !== ref_sr(c, ic) || oinv1 !== ic || cnt1 !== 2'd1) begin n_fail++; $display("FAIL bp_head_c: got %h/%b cnt %0d want %h/%b cnt 1", od1, oinv1, cnt1, ref_sr(c, ic), ic); end
    tick();
    ordy1 = 1'b0;
    n_checks++; if (cnt1 !== 2'd0 || ov1 !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got cnt %0d ov %b want 0/0", cnt1, ov1); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] x;
    logic         m;
    ordy1 = 1'b1;
    v1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x = rnd128();
      m = 1'(i % 2);
      d1 = x; inv1 = m;
      tick();
      n_checks++; if (cnt1 !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 1", i, cnt1); end
      n_checks++; if (od1 !== ref_sr(x, m) || oinv1 !== m) begin n_fail++; $display("FAIL stream_data[%0d]: got %h/%b want %h/%b", i, od1, oinv1, ref_sr(x, m), m); end
    end
    v1 = 1'b0;
    tick();
    ordy1 = 1'b0;
    n_checks++; if (cnt1 !== 2'd0 || ov1 !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got cnt %0d ov %b want 0/0", cnt1, ov1); end
  endtask

  task automatic test_lanes();
    logic [127:0] lane [4];
    for (int pass = 0; pass < 2; pass++) begin
      lane[0] = (pass == 0) ? FIPS_IN : FIPS_OUT;
      for (int k = 1; k < 4; k++) lane[k] = rnd128();
      for (int k = 0; k < 4; k++) d4[128*k +: 128] = lane[k];
      v4 = 1'b1; inv4 = 1'(pass);
      tick();
      v4 = 1'b0;
      n_checks++; if (ov4 !== 1'b1 || cnt4 !== 2'd1 || oinv4 !== 1'(pass)) begin n_fail++; $display("FAIL lanes_valid[%0d]: got ov %b cnt %0d inv %b", pass, ov4, cnt4, oinv4); end
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (od4[128*k +: 128] !== ref_sr(lane[k], 1'(pass))) begin n_fail++; $display("FAIL lanes_data[%0d][%0d]: got %h want %h", pass, k, od4[128*k +: 128], ref_sr(lane[k], 1'(pass))); end
      end
      ordy4 = 1'b1;
      tick();
      ordy4 = 1'b0;
      n_checks++; if (cnt4 !== 2'd0 || od4 !== 512'd0) begin n_fail++; $display("FAIL lanes_drain[%0d]: got cnt %0d data %h", pass, cnt4, od4); end
    end
  endtask

  task automatic test_reset_mid();
    ordy1 = 1'b0;
    v1 = 1'b1;
    d1 = rnd128(); inv1 = 1'b0;
    tick();
    d1 = rnd128(); inv1 = 1'b1;
    tick();
    v1 = 1'b0;
    n_checks++; if (cnt1 !== 2'd2) begin n_fail++; $display("FAIL rstmid_fill: got cnt %0d want 2", cnt1); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (ov1 !== 1'b0 || od1 !== 128'd0 || oinv1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_out: got ov %b data %h inv %b want 0", ov1, od1, oinv1); end
    n_checks++; if (cnt1 !== 2'd0 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got cnt %0d rdy %b want 0/1", cnt1, rdy1); end
    tick();
    rst = 1'b0;
    tick();
    push_and_check("rstmid_fresh", FIPS_IN, 1'b0, FIPS_OUT);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    v1 = 1'b0; inv1 = 1'b0; ordy1 = 1'b0; d1 = '0;
    v4 = 1'b0; inv4 = 1'b0; ordy4 = 1'b0; d4 = '0;
    test_reset();
    test_fips_forward();
    test_inverse_round_trip();
    test_random_single();
    test_back_pressure();
    test_back_to_back();
    test_lanes();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
